// File: rtl/lock_chamber_ctrl_if.sv
// Canal-lock chamber controller bus: boat requests, chamber sensors, emergency hold,
// and the gate/valve/level commands plus grant/done pulses returned by the controller.
// master = traffic/sensor side (drives requests and sensors), slave = the controller.
interface lock_chamber_ctrl_if;
  // requests and sensors (toward the controller)
  logic req_up;
  logic req_dn;
  logic boat_in;
  logic boat_out;
  logic estop;
  // commands and status (from the controller)
  logic gate_up_open;
  logic gate_dn_open;
  logic fill;
  logic drain;
  logic lvl_hi;
  logic grant_up;
  logic grant_dn;
  logic busy;
  logic done;

  modport master (
    output req_up, req_dn, boat_in, boat_out, estop,
    input  gate_up_open, gate_dn_open, fill, drain, lvl_hi,
    input  grant_up, grant_dn, busy, done
  );

  modport slave (
    input  req_up, req_dn, boat_in, boat_out, estop,
    output gate_up_open, gate_dn_open, fill, drain, lvl_hi,
    output grant_up, grant_dn, busy, done
  );
endinterface

// File: rtl/lock_chamber_ctrl.sv
// Purpose: sequences one boat at a time through a canal-lock chamber (arbitrate,
//          level adjust, open entry gate, close, level adjust, open exit gate, close).
// Latency: grant one cycle after a request is seen in IDLE; adjust phases last
//          FILL_CYCLES/DRAIN_CYCLES cycles, close phases GATE_CYCLES cycles.
// Backpressure: requests are level-held and only evaluated in IDLE; estop freezes
//          state and timer and drops the valves.
// Ports: clk, reset (async active-low); bus (slave modport) carries req_up/req_dn,
//        boat_in/boat_out, estop in and gate_up_open/gate_dn_open, fill, drain,
//        lvl_hi, grant_up/grant_dn, busy, done out.
module lock_chamber_ctrl #(
  parameter int unsigned FILL_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned GATE_CYCLES  = 2,
  parameter int unsigned CW           = 8
) (
  input  logic               clk,
  input  logic               reset,
  lock_chamber_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADJ_IN    = 3'd1,
    S_OPEN_IN   = 3'd2,
    S_CLOSE_IN  = 3'd3,
    S_ADJ_OUT   = 3'd4,
    S_OPEN_OUT  = 3'd5,
    S_CLOSE_OUT = 3'd6
  } state_t;

  // Timer load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CW-1:0] FILL_LD  = CW'(FILL_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LD = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] GATE_LD  = CW'(GATE_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_timer;
  logic          r_dir;       // 1 = boat enters from upstream
  logic          r_lvl_hi;
  logic          r_hold;      // estop as seen at the last edge; masks the valves
  logic          r_grant_up;
  logic          r_grant_dn;
  logic          r_done;

  logic          w_win_vld;
  logic          w_win_up;
  logic          w_adj;
  logic [CW-1:0] w_adj_ld;

  // Both sides waiting: the side already at the chamber level goes first, so the
  // next transfer (which flips the level) favours the other side.
  assign w_win_vld = bus.req_up | bus.req_dn;
  assign w_win_up  = bus.req_up & (~bus.req_dn | r_lvl_hi);

  // Every adjust phase moves the water away from the current level.
  assign w_adj_ld  = r_lvl_hi ? DRAIN_LD : FILL_LD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_dir      <= 1'b0;
      r_lvl_hi   <= 1'b0;
      r_hold     <= 1'b0;
      r_grant_up <= 1'b0;
      r_grant_dn <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_grant_up <= 1'b0;
      r_grant_dn <= 1'b0;
      r_done     <= 1'b0;
      r_hold     <= bus.estop;
      if (!bus.estop) begin
        case (r_state)
          S_IDLE: begin
            if (w_win_vld) begin
              r_dir      <= w_win_up;
              r_grant_up <= w_win_up;
              r_grant_dn <= ~w_win_up;
              if (w_win_up != r_lvl_hi) begin
                r_state <= S_ADJ_IN;
                r_timer <= w_adj_ld;
              end else begin
                r_state <= S_OPEN_IN;
              end
            end
          end
          S_ADJ_IN: begin
            if (r_timer == '0) begin
              r_lvl_hi <= ~r_lvl_hi;
              r_state  <= S_OPEN_IN;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          S_OPEN_IN: begin
            if (bus.boat_in) begin
              r_state <= S_CLOSE_IN;
              r_timer <= GATE_LD;
            end
          end
          S_CLOSE_IN: begin
            if (r_timer == '0) begin
              r_state <= S_ADJ_OUT;
              r_timer <= w_adj_ld;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          S_ADJ_OUT: begin
            if (r_timer == '0) begin
              r_lvl_hi <= ~r_lvl_hi;
              r_state  <= S_OPEN_OUT;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          S_OPEN_OUT: begin
            if (bus.boat_out) begin
              r_state <= S_CLOSE_OUT;
              r_timer <= GATE_LD;
            end
          end
          S_CLOSE_OUT: begin
            if (r_timer == '0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Moore decode from registers only. Gates are open only in the OPEN phases and
  // valves only in the ADJ phases, so gate/valve exclusion holds by construction.
  assign w_adj = (r_state == S_ADJ_IN) | (r_state == S_ADJ_OUT);

  assign bus.fill         = w_adj & ~r_lvl_hi & ~r_hold;
  assign bus.drain        = w_adj &  r_lvl_hi & ~r_hold;
  assign bus.gate_up_open = ((r_state == S_OPEN_IN)  &  r_dir) |
                            ((r_state == S_OPEN_OUT) & ~r_dir);
  assign bus.gate_dn_open = ((r_state == S_OPEN_IN)  & ~r_dir) |
                            ((r_state == S_OPEN_OUT) &  r_dir);
  assign bus.lvl_hi       = r_lvl_hi;
  assign bus.grant_up     = r_grant_up;
  assign bus.grant_dn     = r_grant_dn;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = r_done;

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
`timescale 1ns/1ps
module tb_lock_chamber_ctrl;
  localparam int FILL  = 4;
  localparam int DRAIN = 4;
  localparam int GATE  = 2;

  localparam int K_ADJ      = 0;
  localparam int K_OPEN_IN  = 1;
  localparam int K_CLOSE    = 2;
  localparam int K_OPEN_OUT = 3;

  localparam int W_GATE_UP = 0;
  localparam int W_GATE_DN = 1;
  localparam int W_DONE    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  lock_chamber_ctrl_if bus();

  lock_chamber_ctrl #(
    .FILL_CYCLES (FILL),
    .DRAIN_CYCLES(DRAIN),
    .GATE_CYCLES (GATE),
    .CW          (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is a script of phases built at grant time.
  // Timed phases consume one unit per edge without estop; open phases wait for
  // the matching boat sensor.
  int seg_kind[$];
  int seg_left[$];
  bit m_lvl, m_dir, m_est, m_gu, m_gd, m_done, m_up;
  int m_ndone = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_kind.delete();
      seg_left.delete();
      m_lvl = 0; m_dir = 0; m_est = 0; m_gu = 0; m_gd = 0; m_done = 0;
    end else begin
      m_gu = 0; m_gd = 0; m_done = 0;
      m_est = bus.estop;
      if (!bus.estop) begin
        if (seg_kind.size() == 0) begin
          if (bus.req_up || bus.req_dn) begin
            m_up  = bus.req_up && (!bus.req_dn || m_lvl);
            m_dir = m_up;
            m_gu  = m_up;
            m_gd  = !m_up;
            // upstream side is the high level
            if (m_up != m_lvl) begin
              seg_kind.push_back(K_ADJ); seg_left.push_back(m_up ? FILL : DRAIN);
            end
            seg_kind.push_back(K_OPEN_IN);  seg_left.push_back(0);
            seg_kind.push_back(K_CLOSE);    seg_left.push_back(GATE);
            seg_kind.push_back(K_ADJ);      seg_left.push_back(m_up ? DRAIN : FILL);
            seg_kind.push_back(K_OPEN_OUT); seg_left.push_back(0);
            seg_kind.push_back(K_CLOSE);    seg_left.push_back(GATE);
          end
        end else begin
          case (seg_kind[0])
            K_ADJ, K_CLOSE: begin
              seg_left[0] = seg_left[0] - 1;
              if (seg_left[0] == 0) begin
                if (seg_kind[0] == K_ADJ) m_lvl = !m_lvl;
                void'(seg_kind.pop_front());
                void'(seg_left.pop_front());
              end
            end
            K_OPEN_IN: if (bus.boat_in) begin
              void'(seg_kind.pop_front()); void'(seg_left.pop_front());
            end
            K_OPEN_OUT: if (bus.boat_out) begin
              void'(seg_kind.pop_front()); void'(seg_left.pop_front());
            end
            default: ;
          endcase
          if (seg_kind.size() == 0) begin
            m_done = 1;
            m_ndone++;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model plus safety invariants.
  bit cmp_en = 0;
  int e_kind;
  bit e_adj;
  always @(negedge clk) begin
    if (reset && cmp_en) begin
      e_kind = (seg_kind.size() != 0) ? seg_kind[0] : -1;
      e_adj  = (e_kind == K_ADJ) && !m_est;
      chk("m_fill",    bus.fill,         e_adj && !m_lvl);
      chk("m_drain",   bus.drain,        e_adj && m_lvl);
      chk("m_gate_up", bus.gate_up_open, (e_kind == K_OPEN_IN && m_dir) || (e_kind == K_OPEN_OUT && !m_dir));
      chk("m_gate_dn", bus.gate_dn_open, (e_kind == K_OPEN_IN && !m_dir) || (e_kind == K_OPEN_OUT && m_dir));
      chk("m_lvl_hi",  bus.lvl_hi,       m_lvl);
      chk("m_grant_up", bus.grant_up,    m_gu);
      chk("m_grant_dn", bus.grant_dn,    m_gd);
      chk("m_busy",    bus.busy,         seg_kind.size() != 0);
      chk("m_done",    bus.done,         m_done);
      chk("inv_two_gates",  bus.gate_up_open & bus.gate_dn_open, 0);
      chk("inv_fill_drain", bus.fill & bus.drain, 0);
      chk("inv_valve_gate", (bus.fill | bus.drain) & (bus.gate_up_open | bus.gate_dn_open), 0);
      chk("inv_fill_hi",    bus.fill & bus.lvl_hi, 0);
      chk("inv_drain_lo",   bus.drain & ~bus.lvl_hi, 0);
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      W_GATE_UP: return bus.gate_up_open;
      W_GATE_DN: return bus.gate_dn_open;
      W_DONE:    return bus.done;
      default:   return 1'b0;
    endcase
  endfunction

  // Counts cycles (and fill/drain cycles) until the selected output rises.
  task automatic watch(input int sel, input int budget, output int nf, output int nd, output int nc);
    nf = 0; nd = 0; nc = 0;
    while (!sig(sel) && nc < budget) begin
      nf += int'(bus.fill);
      nd += int'(bus.drain);
      nc++;
      @(negedge clk);
    end
    if (!sig(sel)) begin
      checks++;
      errors++;
      $display("FAIL watch_timeout sel=%0d: got 0 after %0d cycles expected 1", sel, nc);
    end
  endtask

  task automatic pulse_in();
    bus.boat_in = 1'b1;
    @(negedge clk);
    bus.boat_in = 1'b0;
  endtask

  task automatic pulse_out();
    bus.boat_out = 1'b1;
    @(negedge clk);
    bus.boat_out = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  int nf, nd, nc;

  initial begin
    bus.req_up = 0; bus.req_dn = 0; bus.boat_in = 0; bus.boat_out = 0; bus.estop = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gate_up", bus.gate_up_open, 0);
    chk("rst_gate_dn", bus.gate_dn_open, 0);
    chk("rst_fill",    bus.fill, 0);
    chk("rst_drain",   bus.drain, 0);
    chk("rst_lvl",     bus.lvl_hi, 0);
    chk("rst_grants",  {bus.grant_up, bus.grant_dn}, 0);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_done",    bus.done, 0);
    reset = 1'b1;
    cmp_en = 1;

    // Downstream boat at low level: no entry adjust, fill on the way out.
    bus.req_dn = 1;
    @(negedge clk);
    chk("s1_grant_dn", bus.grant_dn, 1);
    chk("s1_no_fill", bus.fill, 0);
    chk("s1_gate_dn", bus.gate_dn_open, 1);
    bus.req_dn = 0;
    repeat (3) @(negedge clk);
    chk("s1_gate_dn_hold", bus.gate_dn_open, 1);
    pulse_in();
    watch(W_GATE_UP, 50, nf, nd, nc);
    chk("s1_cyc_to_up", nc, 6);
    chk("s1_fill_cnt", nf, 4);
    chk("s1_drain_cnt", nd, 0);
    chk("s1_lvl", bus.lvl_hi, 1);
    pulse_out();
    watch(W_DONE, 50, nf, nd, nc);
    chk("s1_close_out", nc, 2);
    chk("s1_idle", bus.busy, 0);
    chk("s1_lvl_end", bus.lvl_hi, 1);
    @(negedge clk);
    chk("s1_done_1cyc", bus.done, 0);

    // Upstream boat at low level: fill in, drain out.
    reset_pulse();
    bus.req_up = 1;
    @(negedge clk);
    chk("s2_grant_up", bus.grant_up, 1);
    chk("s2_fill_on", bus.fill, 1);
    bus.req_up = 0;
    watch(W_GATE_UP, 50, nf, nd, nc);
    chk("s2_adj_in_len", nc, 4);
    chk("s2_fill_cnt", nf, 4);
    pulse_in();
    watch(W_GATE_DN, 50, nf, nd, nc);
    chk("s2_cyc_to_dn", nc, 6);
    chk("s2_drain_cnt", nd, 4);
    pulse_out();
    watch(W_DONE, 50, nf, nd, nc);
    chk("s2_lvl_end", bus.lvl_hi, 0);

    // Both sides at low level: down wins, then up with no adjust.
    bus.req_up = 1; bus.req_dn = 1;
    @(negedge clk);
    chk("s3_grant_dn", bus.grant_dn, 1);
    chk("s3_no_grant_up", bus.grant_up, 0);
    bus.req_dn = 0;
    pulse_in();
    watch(W_GATE_UP, 50, nf, nd, nc);
    pulse_out();
    watch(W_DONE, 50, nf, nd, nc);
    chk("s3_lvl_mid", bus.lvl_hi, 1);
    @(negedge clk);
    chk("s3_grant_up", bus.grant_up, 1);
    chk("s3_gate_up_now", bus.gate_up_open, 1);
    chk("s3_no_adj", bus.fill, 0);
    bus.req_up = 0;
    pulse_in();
    watch(W_GATE_DN, 50, nf, nd, nc);
    pulse_out();
    watch(W_DONE, 50, nf, nd, nc);

    // estop during entry fill, held for three sampled edges.
    bus.req_up = 1;
    @(negedge clk);
    chk("s4_fill_c1", bus.fill, 1);
    bus.req_up = 0;
    @(negedge clk);
    chk("s4_fill_c2", bus.fill, 1);
    bus.estop = 1;
    @(negedge clk);
    chk("s4_hold_c3", bus.fill, 0);
    chk("s4_busy_c3", bus.busy, 1);
    @(negedge clk);
    chk("s4_hold_c4", bus.fill, 0);
    @(negedge clk);
    chk("s4_hold_c5", bus.fill, 0);
    chk("s4_gate_closed", bus.gate_up_open, 0);
    bus.estop = 0;
    watch(W_GATE_UP, 50, nf, nd, nc);
    chk("s4_resume_fill", nf, 2);
    chk("s4_resume_len", nc, 3);
    pulse_out();
    chk("s4_stray_out", bus.gate_up_open, 1);
    pulse_in();
    pulse_in();
    watch(W_GATE_DN, 50, nf, nd, nc);
    chk("s4_stray_in_len", nc, 5);
    chk("s4_drain_cnt", nd, 4);
    pulse_out();
    watch(W_DONE, 50, nf, nd, nc);

    // Asynchronous reset in the middle of the exit fill.
    bus.req_dn = 1;
    @(negedge clk);
    bus.req_dn = 0;
    pulse_in();
    repeat (3) @(negedge clk);
    chk("s5_in_adj_out", bus.fill, 1);
    #2 reset = 1'b0;
    #1;
    chk("s5_async_fill", bus.fill, 0);
    chk("s5_async_busy", bus.busy, 0);
    chk("s5_async_lvl", bus.lvl_hi, 0);
    chk("s5_async_gates", {bus.gate_up_open, bus.gate_dn_open}, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s5_no_done", bus.done, 0);
    end
    bus.req_up = 1;
    @(negedge clk);
    chk("s5_new_grant", bus.grant_up, 1);
    bus.req_up = 0;
    watch(W_GATE_UP, 50, nf, nd, nc);
    chk("s5_new_fill", nf, 4);
    pulse_in();
    watch(W_GATE_DN, 50, nf, nd, nc);
    pulse_out();
    watch(W_DONE, 50, nf, nd, nc);
    chk("s5_new_done", bus.done, 1);

    // Random requests, sensors and estop against the model.
    m_ndone = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.grant_up) bus.req_up = 0;
      else if (!bus.req_up && $urandom_range(0, 7) == 0) bus.req_up = 1;
      if (bus.grant_dn) bus.req_dn = 0;
      else if (!bus.req_dn && $urandom_range(0, 7) == 0) bus.req_dn = 1;
      bus.boat_in  = ($urandom_range(0, 5) == 0);
      bus.boat_out = ($urandom_range(0, 5) == 0);
      if (bus.estop) bus.estop = ($urandom_range(0, 2) != 0);
      else           bus.estop = ($urandom_range(0, 19) == 0);
    end
    bus.req_up = 0; bus.req_dn = 0; bus.boat_in = 0; bus.boat_out = 0; bus.estop = 0;
    @(negedge clk);
    chk("rand_some_transfers", m_ndone > 5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lock_chamber_ctrl.md
Name: lock_chamber_ctrl

Overview:
- Sequencer for a canal-lock chamber with an upstream gate and a downstream gate.
- Arbitrates between boats waiting upstream and downstream, and grants the chamber to one at a time.
- Drives fill/drain valves and gate-open commands in a safe order, with timed adjust and close phases.
- Sits above the per-gate open/close FSMs and the water-level datapath, and produces their command inputs.

Parameters:
FILL_CYCLES, 4, cycles fill valve held to raise chamber low->high (>=1)
DRAIN_CYCLES, 4, cycles drain valve held to lower chamber high->low (>=1)
GATE_CYCLES, 2, cycles allowed for a gate to close mechanically after its command drops (>=1)
CW, 8, timer width; every *_CYCLES value must be <= 2^CW

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; clears all state immediately when 0
req_up  in  1  boat waiting at upstream gate (level, held until grant_up)
req_dn  in  1  boat waiting at downstream gate (level, held until grant_dn)
boat_in  in  1  1-cycle pulse: boat fully inside chamber
boat_out  in  1  1-cycle pulse: boat fully out of chamber
estop  in  1  emergency hold (level)
gate_up_open  out  1  open command, upstream gate
gate_dn_open  out  1  open command, downstream gate
fill  out  1  fill valve on
drain  out  1  drain valve on
lvl_hi  out  1  chamber at upstream (high) level
grant_up  out  1  1-cycle pulse: upstream request accepted
grant_dn  out  1  1-cycle pulse: downstream request accepted
busy  out  1  state != IDLE
done  out  1  1-cycle pulse: transfer complete

Behaviour:
- Reset (reset=0, async): state=IDLE, lvl_hi=0, timer=0, dir=0. All other outputs are 0.
- States: IDLE, ADJ_IN, OPEN_IN, CLOSE_IN, ADJ_OUT, OPEN_OUT, CLOSE_OUT.
- dir register: 1 = boat entering from upstream. The entry gate is up if dir=1, dn if dir=0; the exit gate is the other one.
- IDLE, arbitration:
  - Only one req set: that side wins.
  - Both set: the side whose level matches lvl_hi wins (up if lvl_hi=1, dn if lvl_hi=0). Each transfer flips the level, so the other side wins next, and the scheme is starvation-free.
  - Winner latches dir and leaves IDLE on the next edge.
  - Next state is ADJ_IN if the winner's level differs from lvl_hi, else OPEN_IN.
- ADJ_IN / ADJ_OUT:
  - Timer loads N-1 on entry; the state lasts exactly N cycles.
  - N = FILL_CYCLES when raising (fill=1), DRAIN_CYCLES when lowering (drain=1).
  - lvl_hi toggles on the exit edge.
  - ADJ_OUT always toward the exit side's level.
- OPEN_IN: entry gate command=1 until boat_in is sampled high, then CLOSE_IN.
- CLOSE_IN: all gate commands 0 for exactly GATE_CYCLES cycles, then ADJ_OUT.
- OPEN_OUT: exit gate command=1 until boat_out is sampled high, then CLOSE_OUT.
- CLOSE_OUT: exactly GATE_CYCLES cycles, then IDLE.
- Output timing:
  - grant_up/grant_dn/done are registered: high exactly one cycle.
  - grant: first cycle after leaving IDLE.
  - done: first cycle back in IDLE.
- Safety invariants (must hold every cycle): never both gate commands=1; never fill and drain together; fill/drain never 1 while any gate command=1; fill only when lvl_hi=0, drain only when lvl_hi=1.
- Gate, valve and level outputs are decoded from state, dir and lvl_hi (Moore, no input-to-output paths).
- estop=1:
  - State and timer freeze.
  - fill and drain are forced 0.
  - Gate commands hold their current value.
  - boat_in/boat_out are ignored.
  - Requests are not granted in IDLE.
  - On release, the timer resumes from the frozen value.
- boat_in outside OPEN_IN and boat_out outside OPEN_OUT are ignored.
- Requests arriving while busy wait; they are evaluated only in IDLE.
- Reset mid-transfer aborts to IDLE, lvl_hi=0, with no done pulse.

Test Plan:
- Reset, lvl_hi=0, req_dn=1 -> grant_dn next cycle; no fill; gate_dn_open=1 until boat_in; 2 closed cycles; drain=0 and fill=1 for exactly 4 cycles; lvl_hi=1; gate_up_open until boat_out; 2 cycles; done=1 one cycle; lvl_hi=1.
- From lvl_hi=0, req_up=1 -> fill=1 exactly 4 cycles before gate_up_open; after boat_in, drain=1 exactly 4 cycles; gate_dn_open; done; lvl_hi=0.
- req_up=req_dn=1 together at lvl_hi=0 -> grant_dn first; after its done (lvl_hi=1), grant_up with no ADJ_IN.
- estop raised in cycle 2 of FILL, held 3 cycles -> fill drops for 3 cycles, state held; on release, fill resumes for the remaining 2 cycles (4 total fill cycles).
- Stray boat_out during OPEN_IN and boat_in during CLOSE_IN -> no state change; assertion checker confirms all safety invariants over 1000 random request/sensor cycles.
- reset pulsed low mid-ADJ_OUT -> all outputs 0 immediately (asynchronous), lvl_hi=0, no done; a new req is served normally after release.
